// File: rtl/efuse_macro_emu.sv
// 256-bit OTP eFuse macro emulator: answers efuse_ctrl PGM/READ pulses and flags protocol errors.
// Optional preload of the fuse image at reset is enabled by EFUSE_EMU_PRELOAD_EN.
module efuse_macro_emu #(
  parameter int           TRD_MIN  = 2,
  parameter int           TPGM_MIN = 2,
  parameter logic [255:0] INIT_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         efuse_pgmen_i,
  input  logic         efuse_rden_i,
  input  logic         efuse_aen_i,
  input  logic [7:0]   efuse_addr_i,
  output logic [7:0]   efuse_rdata_o,
  input  logic         emu_err_clr,
  output logic         emu_timing_err,
  output logic         emu_proto_err,
  output logic [8:0]   emu_pgm_cnt,
  output logic [255:0] emu_fuse_bits
);

  typedef enum logic [1:0] {IDLE, RD_PULSE, PGM_PULSE, ABORT} state_t;

  function automatic logic [8:0] popcnt(input logic [255:0] v);
    logic [8:0] c;
    c = '0;
    for (int i = 0; i < 256; i++) c = c + 9'(v[i]);
    return c;
  endfunction

`ifdef EFUSE_EMU_PRELOAD_EN
  localparam bit PRELOAD = 1'b1;
`else
  localparam bit PRELOAD = 1'b0;
`endif
  localparam logic [255:0] ARR_RST = PRELOAD ? INIT_VAL : '0;
  localparam logic [8:0]   CNT_RST = popcnt(ARR_RST);
  localparam logic [9:0]   TRD     = 10'(TRD_MIN);
  localparam logic [9:0]   TPGM    = 10'(TPGM_MIN);

  state_t       state_q, state_d;
  logic         aen_q;
  logic [7:0]   addr_q, addr_d;
  logic [9:0]   wcnt_q, wcnt_d;
  logic [7:0]   rdata_q, rdata_d;
  logic         tim_q, tim_d;
  logic         proto_q, proto_d;
  logic [8:0]   cnt_q, cnt_d;
  logic [255:0] arr_q, arr_d;

  logic rise, fall, tset, pset, op_chg;

  assign rise = efuse_aen_i & ~aen_q;
  assign fall = ~efuse_aen_i & aen_q;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wcnt_d  = wcnt_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    arr_d   = arr_q;
    tset    = 1'b0;
    pset    = 1'b0;
    op_chg  = (state_q == RD_PULSE) ? (efuse_pgmen_i | ~efuse_rden_i)
                                    : (~efuse_pgmen_i | efuse_rden_i);
    case (state_q)
      IDLE: begin
        if (rise) begin
          addr_d = efuse_addr_i;
          wcnt_d = 10'd1;
          if (efuse_pgmen_i & ~efuse_rden_i)      state_d = PGM_PULSE;
          else if (efuse_rden_i & ~efuse_pgmen_i) state_d = RD_PULSE;
          else begin
            state_d = ABORT;
            pset    = 1'b1;
          end
        end
      end
      RD_PULSE, PGM_PULSE: begin
        if (efuse_aen_i) begin
          if (op_chg || efuse_addr_i != addr_q) begin
            state_d = ABORT;
            pset    = 1'b1;
          end else if (wcnt_q != 10'h3FF) begin
            wcnt_d = wcnt_q + 10'd1;
          end
        end else if (fall) begin
          state_d = IDLE;
          if (state_q == RD_PULSE) begin
            rdata_d = 8'h00;
            if (addr_q[7:5] != 3'b000) pset = 1'b1;
            else if (wcnt_q < TRD)     tset = 1'b1;
            else rdata_d = arr_q[{addr_q[4:0], 3'b000} +: 8];
          end else if (wcnt_q < TPGM) begin
            tset = 1'b1;
          end else begin
            // Re-blowing an already set bit is legal and leaves the count alone
            if (!arr_q[addr_q]) cnt_d = cnt_q + 9'd1;
            arr_d[addr_q] = 1'b1;
          end
        end
      end
      ABORT: begin
        if (!efuse_aen_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    tim_d   = tset | (tim_q & ~emu_err_clr);
    proto_d = pset | (proto_q & ~emu_err_clr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      aen_q   <= 1'b0;
      addr_q  <= '0;
      wcnt_q  <= '0;
      rdata_q <= '0;
      tim_q   <= 1'b0;
      proto_q <= 1'b0;
      cnt_q   <= CNT_RST;
      arr_q   <= ARR_RST;
    end else begin
      state_q <= state_d;
      aen_q   <= efuse_aen_i;
      addr_q  <= addr_d;
      wcnt_q  <= wcnt_d;
      rdata_q <= rdata_d;
      tim_q   <= tim_d;
      proto_q <= proto_d;
      cnt_q   <= cnt_d;
      arr_q   <= arr_d;
    end
  end

  assign efuse_rdata_o  = rdata_q;
  assign emu_timing_err = tim_q;
  assign emu_proto_err  = proto_q;
  assign emu_pgm_cnt    = cnt_q;
  assign emu_fuse_bits  = arr_q;

endmodule
